// File: rtl/saph_pkg.sv
// saph_pkg: shared colour types, colour-math mode codes and the operation bundle
// used by the colour-math datapath and the blocks that feed it.
package saph_pkg;
   typedef logic [31:0] color;
   localparam int SAPH_COLMATH_MODE_W = 3;
   typedef logic [SAPH_COLMATH_MODE_W-1:0] colmath_mode_t;
   localparam colmath_mode_t SAPH_COLMATH_ADD    = 3'd0;
   localparam colmath_mode_t SAPH_COLMATH_MUL    = 3'd1;
   localparam colmath_mode_t SAPH_COLMATH_INTERP = 3'd2;
   localparam colmath_mode_t SAPH_COLMATH_SCALE  = 3'd3;
   typedef struct packed {
      color          a;
      color          b;
      logic [7:0]    c;
      colmath_mode_t mode;
   } colmath_op_t;
endpackage

// File: rtl/saph_colmath.sv
// saph_colmath: per-channel 8-bit colour math (saturating add, multiply, lerp, scale).
// Unknown modes return operand A untouched.
module saph_colmath
   import saph_pkg::*;
(
   input  colmath_op_t op,
   output color        y
);
   function automatic logic [7:0] chan(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input colmath_mode_t m);
      logic [8:0]  s;
      logic [15:0] mul, sc, lerp;
      s    = {1'b0, a} + {1'b0, b};
      mul  = 16'(a) * 16'(b);
      sc   = 16'(a) * 16'(c);
      lerp = 16'(a) * (16'd256 - 16'(c)) + 16'(b) * 16'(c);
      return m == SAPH_COLMATH_ADD    ? (s[8] ? 8'hff : s[7:0]) :
             m == SAPH_COLMATH_MUL    ? 8'(mul >> 8) :
             m == SAPH_COLMATH_INTERP ? 8'(lerp >> 8) :
             m == SAPH_COLMATH_SCALE  ? 8'(sc >> 8) : a;
   endfunction

   always_comb begin
      y = '0;
      for (int i = 0; i < 4; i++)
         y[8*i +: 8] = chan(op.a[8*i +: 8], op.b[8*i +: 8], op.c, op.mode);
   end
endmodule

// File: rtl/saph_rr_pick.sv
// saph_rr_pick: combinational round-robin picker; the winner is the first valid
// index strictly after last, searching modulo N.
module saph_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);
   // Scan farthest-first so the nearest valid index overwrites earlier hits.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = N; k >= 1; k--) begin
         if (valid[(int'(last) + k) % N]) begin
            gnt = N'(1) << ((int'(last) + k) % N);
            idx = IW'((int'(last) + k) % N);
            any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/saph_colmath_arb.sv
// saph_colmath_arb: round-robin arbiter sharing one saph_colmath among NREQ
// requesters, with a registered, id-tagged response slot.
module saph_colmath_arb
   import saph_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic          [NREQ-1:0]       req_valid,
   output logic          [NREQ-1:0]       req_ready,
   input  color          [NREQ-1:0]       req_a,
   input  color          [NREQ-1:0]       req_b,
   input  logic          [NREQ-1:0][7:0]  req_c,
   input  colmath_mode_t [NREQ-1:0]       req_mode,
   output logic                           resp_valid,
   input  logic                           resp_ready,
   output color                           resp_q,
   output logic          [IDW-1:0]        resp_id,
   output logic          [31:0]           issue_count
);
   colmath_op_t [NREQ-1:0] ops;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  idx, id_q, id_d, last_q, last_d;
   logic            any, can_issue, issue, valid_q, valid_d;
   color            y, data_q, data_d;
   logic [31:0]     count_q, count_d;

   saph_rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
      .valid (req_valid),
      .last  (last_q),
      .gnt   (gnt),
      .idx   (idx),
      .any   (any)
   );

   saph_colmath u_colmath (
      .op (ops[idx]),
      .y  (y)
   );

   always_comb begin
      for (int i = 0; i < NREQ; i++)
         ops[i] = {req_a[i], req_b[i], req_c[i], req_mode[i]};
      can_issue = !valid_q || resp_ready;
      issue     = can_issue && any;
      req_ready = (can_issue && rst_n) ? gnt : '0;
      valid_d   = issue || (valid_q && !resp_ready);
      data_d    = issue ? y : data_q;
      id_d      = issue ? idx : id_q;
      last_d    = issue ? idx : last_q;
      count_d   = count_q + 32'(issue);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         id_q    <= '0;
         last_q  <= IDW'(NREQ - 1);
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         id_q    <= id_d;
         last_q  <= last_d;
         count_q <= count_d;
      end
   end

   assign resp_valid  = valid_q;
   assign resp_q      = data_q;
   assign resp_id     = id_q;
   assign issue_count = count_q;
endmodule

// File: tb/tb_saph_colmath_arb.sv
// tb_saph_colmath_arb: randomized bench for the colour-math arbiter against a
// behavioural model of arbitration, response slot and per-channel colour math.
module tb_saph_colmath_arb;
   import saph_pkg::*;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [N-1:0] req_valid = '0;
   logic [N-1:0] req_ready;
   color [N-1:0] req_a, req_b;
   logic [N-1:0][7:0] req_c;
   colmath_mode_t [N-1:0] req_mode;
   logic resp_valid;
   logic resp_ready = 1'b0;
   color resp_q;
   logic [1:0] resp_id;
   logic [31:0] issue_count;

   int checks = 0, failures = 0;

   int m_last = N - 1;
   bit m_valid = 0;
   logic [31:0] m_q = '0;
   int m_id = 0;
   logic [31:0] m_cnt = '0;
   logic [N-1:0] m_ready;
   int m_win;
   logic [N-1:0] obs_ready, exp_ready;

   saph_colmath_arb #(.NREQ(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_c       (req_c),
      .req_mode    (req_mode),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_q      (resp_q),
      .resp_id     (resp_id),
      .issue_count (issue_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] cm(input logic [31:0] a, input logic [31:0] b,
                                      input logic [7:0] c, input colmath_mode_t m);
      int x, y, r, ci;
      logic [31:0] res;
      res = '0;
      ci = int'(c);
      for (int ch = 0; ch < 4; ch++) begin
         x = int'(a[8*ch +: 8]);
         y = int'(b[8*ch +: 8]);
         if (m == SAPH_COLMATH_ADD) r = (x + y > 255) ? 255 : x + y;
         else if (m == SAPH_COLMATH_MUL) r = x * y / 256;
         else if (m == SAPH_COLMATH_INTERP) r = (x * (256 - ci) + y * ci) / 256;
         else if (m == SAPH_COLMATH_SCALE) r = x * ci / 256;
         else r = x;
         res[8*ch +: 8] = r[7:0];
      end
      return res;
   endfunction

   task automatic new_op(input int r);
      req_a[r]    = $urandom;
      req_b[r]    = $urandom;
      req_c[r]    = 8'($urandom_range(0, 255));
      req_mode[r] = colmath_mode_t'($urandom_range(0, 7));
   endtask

   task automatic m_reset();
      m_last = N - 1; m_valid = 0; m_q = '0; m_id = 0; m_cnt = '0;
   endtask

   task automatic pick();
      m_win = -1;
      for (int k = 1; k <= N; k++)
         if (req_valid[(m_last + k) % N] && m_win < 0) m_win = (m_last + k) % N;
      m_ready = (rst_n && (!m_valid || resp_ready) && m_win >= 0) ? N'(1) << m_win : '0;
   endtask

   // One clock: sample req_ready mid-cycle, then advance the model past the edge.
   task automatic tick();
      logic [31:0] nq;
      int w;
      pick();
      #1;
      obs_ready = req_ready;
      exp_ready = m_ready;
      w = m_win;
      nq = (w >= 0) ? cm(req_a[w], req_b[w], req_c[w], req_mode[w]) : '0;
      @(posedge clk);
      #1;
      if (exp_ready != '0) begin
         m_q = nq; m_id = w; m_valid = 1; m_last = w; m_cnt++;
         new_op(w);
      end else if (m_valid && resp_ready) m_valid = 0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      m_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req_valid = 4'b1111;
      resp_ready = 1'b1;
      #2;
      checks += 4;
      if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
      if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
      if (issue_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", issue_count); end
      if (resp_q !== 32'd0) begin failures++; $display("FAIL reset_q got=%h exp=0", resp_q); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      checks += 3;
      if (obs_ready !== 4'b0001) begin failures++; $display("FAIL first_grant got=%b exp=0001", obs_ready); end
      if (resp_id !== 2'd0) begin failures++; $display("FAIL first_id got=%0d exp=0", resp_id); end
      if (resp_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", resp_valid); end
   endtask

   task automatic test_single_op();
      logic [31:0] exp_q;
      req_valid = '0;
      tick();
      req_a[2] = 32'h7fff0000; req_b[2] = 32'hff00ff00; req_c[2] = 8'h7f;
      req_mode[2] = SAPH_COLMATH_INTERP;
      exp_q = cm(32'h7fff0000, 32'hff00ff00, 8'h7f, SAPH_COLMATH_INTERP);
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      checks += 4;
      if (obs_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", obs_ready); end
      if (resp_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", resp_valid); end
      if (resp_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d exp=2", resp_id); end
      if (resp_q !== exp_q) begin failures++; $display("FAIL single_q got=%h exp=%h", resp_q, exp_q); end
      tick();
      checks++;
      if (resp_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", resp_valid); end
   endtask

   task automatic test_fairness();
      int gc[N];
      apply_reset();
      for (int r = 0; r < N; r++) gc[r] = 0;
      req_valid = 4'b1111;
      resp_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         for (int r = 0; r < N; r++) if (obs_ready[r]) gc[r]++;
         checks += 3;
         if (obs_ready !== 4'(1 << (i % N))) begin failures++; $display("FAIL fair_order cyc=%0d got=%b exp=%b", i, obs_ready, 4'(1 << (i % N))); end
         if (resp_id !== 2'(i % N)) begin failures++; $display("FAIL fair_id cyc=%0d got=%0d exp=%0d", i, resp_id, i % N); end
         if (resp_q !== m_q) begin failures++; $display("FAIL fair_q cyc=%0d got=%h exp=%h", i, resp_q, m_q); end
      end
      checks++;
      if (issue_count !== 32'd16) begin failures++; $display("FAIL fair_count got=%0d exp=16", issue_count); end
      for (int r = 0; r < N; r++) begin
         checks++;
         if (gc[r] != 4) begin failures++; $display("FAIL fair_share id=%0d got=%0d exp=4", r, gc[r]); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] sq, sc;
      logic [1:0] sid;
      req_valid = 4'b1111;
      resp_ready = 1'b0;
      sq = resp_q; sid = resp_id; sc = issue_count;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks += 4;
         if (obs_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=0000", i, obs_ready); end
         if (resp_q !== sq) begin failures++; $display("FAIL bp_q cyc=%0d got=%h exp=%h", i, resp_q, sq); end
         if (resp_id !== sid) begin failures++; $display("FAIL bp_id cyc=%0d got=%0d exp=%0d", i, resp_id, sid); end
         if (issue_count !== sc) begin failures++; $display("FAIL bp_count cyc=%0d got=%0d exp=%0d", i, issue_count, sc); end
      end
      resp_ready = 1'b1;
      tick();
      checks += 3;
      if (obs_ready !== 4'(1 << ((int'(sid) + 1) % N))) begin failures++; $display("FAIL bp_resume got=%b exp=%b", obs_ready, 4'(1 << ((int'(sid) + 1) % N))); end
      if (resp_q !== m_q) begin failures++; $display("FAIL bp_resume_q got=%h exp=%h", resp_q, m_q); end
      if (issue_count !== sc + 1) begin failures++; $display("FAIL bp_resume_count got=%0d exp=%0d", issue_count, sc + 1); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] c0;
      req_valid = 4'b0010;
      resp_ready = 1'b1;
      c0 = issue_count;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks += 4;
         if (resp_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid cyc=%0d got=%b exp=1", i, resp_valid); end
         if (resp_id !== 2'd1) begin failures++; $display("FAIL b2b_id cyc=%0d got=%0d exp=1", i, resp_id); end
         if (resp_q !== m_q) begin failures++; $display("FAIL b2b_q cyc=%0d got=%h exp=%h", i, resp_q, m_q); end
         if (issue_count !== c0 + 32'(i + 1)) begin failures++; $display("FAIL b2b_count cyc=%0d got=%0d exp=%0d", i, issue_count, c0 + 32'(i + 1)); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         req_valid = 4'($urandom);
         resp_ready = ($urandom_range(0, 3) != 0);
         tick();
         checks += 4;
         if (obs_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, obs_ready, exp_ready); end
         if (resp_valid !== m_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, resp_valid, m_valid); end
         if (issue_count !== m_cnt) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, issue_count, m_cnt); end
         if (m_valid && (resp_q !== m_q || resp_id !== 2'(m_id))) begin
            failures++; $display("FAIL rnd_data cyc=%0d got=%h/%0d exp=%h/%0d", i, resp_q, resp_id, m_q, m_id);
         end
      end
   endtask

   task automatic test_mid_reset();
      req_valid = 4'b1111;
      resp_ready = 1'b1;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      checks += 4;
      if (resp_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", resp_valid); end
      if (issue_count !== 32'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", issue_count); end
      if (req_ready !== 4'b0000) begin failures++; $display("FAIL mid_ready got=%b exp=0000", req_ready); end
      if (resp_id !== 2'd0) begin failures++; $display("FAIL mid_id got=%0d exp=0", resp_id); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req_valid = 4'b1010;
      tick();
      checks += 2;
      if (obs_ready !== 4'b0010) begin failures++; $display("FAIL mid_regrant got=%b exp=0010", obs_ready); end
      if (issue_count !== 32'd1) begin failures++; $display("FAIL mid_recount got=%0d exp=1", issue_count); end
   endtask

   initial begin
      for (int r = 0; r < N; r++) new_op(r);
      test_reset();
      test_single_op();
      test_fairness();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
